// File: rtl/ticket_dispatch.sv
// ticket_dispatch
//   Issues sequential customer tickets on a take-number button, holds them in
//   order, and dispatches the oldest waiting ticket to the lowest-index idle,
//   enabled service counter. Each dispatched counter stays busy for a fixed
//   number of service cycles.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous active-high reset
//   button         : take-number request (level, edge-detected here)
//   counter_en     : per-counter open mask (1 = may receive new tickets)
//   last_ticket    : most recently issued ticket number
//   waiting        : tickets issued but not yet dispatched
//   queue_full     : waiting == QUEUE_DEPTH
//   reject         : one-cycle pulse on a request while the queue is full
//   counter_busy   : per-counter busy flags
//   counter_ticket : ticket last assigned to each counter, TICKET_W per counter
//   call_valid     : one-cycle pulse on each dispatch
//   call_counter   : counter index receiving the dispatch
//   call_ticket    : ticket number dispatched
module ticket_dispatch #(
    parameter int NUM_COUNTERS   = 5,
    parameter int TICKET_W       = 6,
    parameter int QUEUE_DEPTH    = 15,
    parameter int SERVICE_CYCLES = 8,
    localparam int WAIT_W        = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             button,
    input  logic [NUM_COUNTERS-1:0]          counter_en,
    output logic [TICKET_W-1:0]              last_ticket,
    output logic [WAIT_W-1:0]                waiting,
    output logic                             queue_full,
    output logic                             reject,
    output logic [NUM_COUNTERS-1:0]          counter_busy,
    output logic [NUM_COUNTERS*TICKET_W-1:0] counter_ticket,
    output logic                             call_valid,
    output logic [2:0]                       call_counter,
    output logic [TICKET_W-1:0]              call_ticket
);

    localparam int TIMER_W = $clog2(SERVICE_CYCLES + 1);
    localparam logic [WAIT_W-1:0]   FULL_COUNT = WAIT_W'(QUEUE_DEPTH);
    localparam logic [TIMER_W-1:0]  SERVICE_LD = TIMER_W'(SERVICE_CYCLES);
    localparam logic [TICKET_W-1:0] FIRST_TKT  = TICKET_W'(1);

    logic                    button_d;
    logic [TICKET_W-1:0]     next_issue;
    logic [TICKET_W-1:0]     next_serve;
    logic [TIMER_W-1:0]      timer [NUM_COUNTERS];

    logic                    request;
    logic                    issue;
    logic [NUM_COUNTERS-1:0] free;
    logic                    found;
    logic [2:0]              sel;
    logic                    dispatch;

    // Ticket numbers skip 0, which is reserved for "none".
    function automatic logic [TICKET_W-1:0] next_num(input logic [TICKET_W-1:0] t);
        return (t == '1) ? FIRST_TKT : t + FIRST_TKT;
    endfunction

    assign request    = button & ~button_d;
    assign queue_full = (waiting == FULL_COUNT);
    assign issue      = request & ~queue_full;
    assign free       = counter_en & ~counter_busy;

    // Lowest-index eligible counter wins.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            if (!found && free[i]) begin
                sel   = 3'(i);
                found = 1'b1;
            end
        end
    end

    assign dispatch = (waiting != '0) && found;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            button_d       <= 1'b0;
            next_issue     <= FIRST_TKT;
            next_serve     <= FIRST_TKT;
            last_ticket    <= '0;
            waiting        <= '0;
            reject         <= 1'b0;
            call_valid     <= 1'b0;
            call_counter   <= '0;
            call_ticket    <= '0;
            counter_busy   <= '0;
            counter_ticket <= '0;
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                timer[i] <= '0;
            end
        end else begin
            button_d <= button;
            reject   <= request & queue_full;

            if (issue) begin
                last_ticket <= next_issue;
                next_issue  <= next_num(next_issue);
            end

            // Issue and dispatch in the same cycle cancel out.
            if (issue && !dispatch) begin
                waiting <= waiting + WAIT_W'(1);
            end else if (!issue && dispatch) begin
                waiting <= waiting - WAIT_W'(1);
            end

            call_valid   <= dispatch;
            call_counter <= dispatch ? sel : '0;
            call_ticket  <= dispatch ? next_serve : '0;
            if (dispatch) begin
                next_serve <= next_num(next_serve);
            end

            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                if (dispatch && sel == 3'(i)) begin
                    counter_busy[i]                        <= 1'b1;
                    timer[i]                               <= SERVICE_LD;
                    counter_ticket[i*TICKET_W +: TICKET_W] <= next_serve;
                end else if (counter_busy[i]) begin
                    timer[i] <= timer[i] - TIMER_W'(1);
                    if (timer[i] == TIMER_W'(1)) begin
                        counter_busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ticket_dispatch.sv
module tb_ticket_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        button = 1'b0;
    logic [4:0]  counter_en = '0;
    logic [5:0]  last_ticket;
    logic [3:0]  waiting;
    logic        queue_full;
    logic        reject;
    logic [4:0]  counter_busy;
    logic [29:0] counter_ticket;
    logic        call_valid;
    logic [2:0]  call_counter;
    logic [5:0]  call_ticket;

    // Narrow-ticket instance for number wrap.
    logic        w_button = 1'b0;
    logic [0:0]  w_en = '0;
    logic [2:0]  w_last;
    logic [2:0]  w_waiting;
    logic        w_full;
    logic        w_reject;
    logic [0:0]  w_busy;
    logic [2:0]  w_cticket;
    logic        w_call_valid;
    logic [2:0]  w_call_counter;
    logic [2:0]  w_call_ticket;

    int checks   = 0;
    int failures = 0;

    logic [8:0] sb [$];     // {counter[2:0], ticket[5:0]}
    logic [2:0] sbw [$];

    always #5 clk = ~clk;

    ticket_dispatch #(
        .NUM_COUNTERS(5), .TICKET_W(6), .QUEUE_DEPTH(15), .SERVICE_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .counter_en(counter_en),
        .last_ticket(last_ticket), .waiting(waiting), .queue_full(queue_full),
        .reject(reject), .counter_busy(counter_busy), .counter_ticket(counter_ticket),
        .call_valid(call_valid), .call_counter(call_counter), .call_ticket(call_ticket)
    );

    ticket_dispatch #(
        .NUM_COUNTERS(1), .TICKET_W(3), .QUEUE_DEPTH(6), .SERVICE_CYCLES(1)
    ) dut_w (
        .clk(clk), .rst(rst), .button(w_button), .counter_en(w_en),
        .last_ticket(w_last), .waiting(w_waiting), .queue_full(w_full),
        .reject(w_reject), .counter_busy(w_busy), .counter_ticket(w_cticket),
        .call_valid(w_call_valid), .call_counter(w_call_counter), .call_ticket(w_call_ticket)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard monitors: pop an expected call whenever the DUT announces one.
    always @(negedge clk) begin
        if (call_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_call", {26'd0, call_counter, call_ticket}, 32'd0);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                check("call_counter", 32'(call_counter), 32'(e[8:6]));
                check("call_ticket", 32'(call_ticket), 32'(e[5:0]));
            end
        end
        if (w_call_valid) begin
            if (sbw.size() == 0) begin
                check("w_unexpected_call", 32'(w_call_ticket), 32'd0);
            end else begin
                logic [2:0] ew;
                ew = sbw.pop_front();
                check("w_call_ticket", 32'(w_call_ticket), 32'(ew));
            end
        end
    end

    task automatic expect_call(input int c, input int t);
        sb.push_back({3'(c), 6'(t)});
    endtask

    // All tasks start and end 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        button = 1'b1;
        tick(1);
        button = 1'b0;
        tick(1);
    endtask

    task automatic do_reset(input string tag);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
        sb.delete();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        #7;
        check("rst_last_ticket", 32'(last_ticket), 32'd0);
        check("rst_waiting", 32'(waiting), 32'd0);
        check("rst_outputs", {19'd0, queue_full, reject, call_valid, counter_busy, call_counter}, 32'd0);
        check("rst_counter_ticket", counter_ticket[29:0], 32'd0);
        rst = 1'b0;
        tick(1);

        // Single ticket
        counter_en = 5'b11111;
        expect_call(0, 1);
        button = 1'b1;
        tick(1);                                   // E0
        check("single_last", 32'(last_ticket), 32'd1);
        check("single_wait_e0", 32'(waiting), 32'd1);
        button = 1'b0;
        tick(1);                                   // E1
        check("single_wait_e1", 32'(waiting), 32'd0);
        check("single_busy_e1", 32'(counter_busy), 32'b00001);
        tick(7);                                   // E8
        check("single_busy_e8", 32'(counter_busy), 32'b00001);
        tick(1);                                   // E9
        check("single_busy_e9", 32'(counter_busy), 32'b00000);
        check("single_ct0_hold", 32'(counter_ticket[5:0]), 32'd1);

        // Burst of 7
        do_reset("single");
        counter_en = 5'b11111;
        for (int i = 0; i < 5; i++) expect_call(i, i + 1);
        expect_call(0, 6);
        expect_call(1, 7);
        for (int i = 0; i < 7; i++) pulse();
        tick(4);
        check("burst_last", 32'(last_ticket), 32'd7);
        check("burst_wait", 32'(waiting), 32'd0);
        check("burst_ct4", 32'(counter_ticket[29:24]), 32'd5);

        // Issue and dispatch on the same edge
        do_reset("burst");
        counter_en = 5'b00000;
        pulse();
        pulse();
        check("simul_pre_wait", 32'(waiting), 32'd2);
        expect_call(0, 1);
        counter_en = 5'b00001;
        button = 1'b1;
        tick(1);
        check("simul_wait", 32'(waiting), 32'd2);
        check("simul_last", 32'(last_ticket), 32'd3);
        button = 1'b0;
        tick(2);

        // Full queue
        do_reset("simul");
        counter_en = 5'b00000;
        for (int i = 0; i < 15; i++) pulse();
        check("full_wait", 32'(waiting), 32'd15);
        check("full_flag", 32'(queue_full), 32'd1);
        check("full_reject_idle", 32'(reject), 32'd0);
        button = 1'b1;
        tick(1);
        check("full_reject", 32'(reject), 32'd1);
        check("full_last", 32'(last_ticket), 32'd15);
        check("full_wait_hold", 32'(waiting), 32'd15);
        button = 1'b0;
        tick(1);
        check("full_reject_clr", 32'(reject), 32'd0);
        expect_call(2, 1);
        counter_en = 5'b00100;
        tick(2);
        check("full_drain_wait", 32'(waiting), 32'd14);
        check("full_drain_flag", 32'(queue_full), 32'd0);
        check("full_busy", 32'(counter_busy), 32'b00100);

        // Held button, then reset mid-service
        do_reset("full");
        counter_en = 5'b11111;
        expect_call(0, 1);
        button = 1'b1;
        tick(10);
        button = 1'b0;
        tick(2);
        check("held_last", 32'(last_ticket), 32'd1);
        check("held_wait", 32'(waiting), 32'd0);
        counter_en = 5'b01000;
        tick(8);
        expect_call(3, 2);
        pulse();
        tick(1);
        check("mid_busy", 32'(counter_busy), 32'b01000);
        check("mid_ct3", 32'(counter_ticket[23:18]), 32'd2);
        check({"mid", "_sb_drained"}, 32'(sb.size()), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(counter_busy), 32'd0);
        check("mid_rst_wait", 32'(waiting), 32'd0);
        #1;
        rst = 1'b0;
        tick(1);
        counter_en = 5'b11111;
        expect_call(0, 1);
        pulse();
        check("mid_next_ticket", 32'(last_ticket), 32'd1);
        tick(2);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        // Number wrap on the 3-bit instance
        w_en = 1'b1;
        begin
            logic [2:0] seq [8];
            seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
            for (int i = 0; i < 8; i++) begin
                sbw.push_back(seq[i]);
                w_button = 1'b1;
                tick(1);
                check("wrap_last", 32'(w_last), 32'(seq[i]));
                w_button = 1'b0;
                tick(2);
            end
        end
        check("wrap_wait", 32'(w_waiting), 32'd0);
        check("wrap_sb_drained", 32'(sbw.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
